// File: rtl/vga_bitmap_scanner_if.sv
// Bitmap read port between the VGA scanner (master) and the pixel memory (slave).
// rd_data is expected exactly one clock after rd_en.
interface vga_bitmap_scanner_if;
  logic [8:0] rd_x;
  logic [7:0] rd_y;
  logic       rd_en;
  logic [2:0] rd_data;

  modport master (output rd_x, output rd_y, output rd_en, input rd_data);
  modport slave  (input rd_x, input rd_y, input rd_en, output rd_data);
endinterface

// File: rtl/vga_bitmap_scanner.sv
// Scans a 320x240 {R,G,B} bitmap out as 640x480@60 VGA with 2x2 pixel doubling.
// One system clock; pixel rate is clk / CLK_DIV.
module vga_bitmap_scanner #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_VIS   = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_VIS   = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic                        clk,
  input  logic                        reset_n,
  vga_bitmap_scanner_if.master        rd,
  output logic [3:0]                  VGA_R,
  output logic [3:0]                  VGA_G,
  output logic [3:0]                  VGA_B,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic                        frame_start,
  output logic                        in_vblank
);

  localparam logic [2:0] DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  // Timing of the pixel whose memory read is in flight; it waits one clock for rd_data.
  typedef struct packed {
    logic upd;
    logic vis;
    logic hs_n;
    logic vs_n;
    logic fs;
  } stage_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs_n;
    logic       vs_n;
    logic       fs;
    logic       vblank;
  } out_t;

  localparam stage_t STAGE_RST = '{upd: 1'b0, vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};
  localparam out_t   OUT_RST   = '{r: 4'h0, g: 4'h0, b: 4'h0, hs_n: 1'b1, vs_n: 1'b1,
                                   fs: 1'b0, vblank: 1'b0};

  logic [2:0] div_q, div_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  stage_t     stg_q, stg_d;
  out_t       out_q, out_d;
  logic       pix_en;
  logic       visible;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    pix_en  = (div_q == DIV_LAST);
    visible = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);

    div_d   = div_q + 3'd1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      div_d = 3'd0;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end

    // The pixel at the current counters is read during the last divider phase,
    // so the scan after reset starts at (0,0) on the first pix_en.
    stg_d.upd  = pix_en;
    stg_d.vis  = pix_en & visible;
    stg_d.hs_n = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    stg_d.vs_n = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    stg_d.fs   = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    out_d        = out_q;
    out_d.fs     = 1'b0;
    out_d.vblank = (v_cnt_q >= V_VIS_C);
    if (stg_q.upd) begin
      // rd_data is only looked at for visible pixels, so X during blanking cannot leak.
      out_d.r    = stg_q.vis ? {4{rd.rd_data[2]}} : 4'h0;
      out_d.g    = stg_q.vis ? {4{rd.rd_data[1]}} : 4'h0;
      out_d.b    = stg_q.vis ? {4{rd.rd_data[0]}} : 4'h0;
      out_d.hs_n = stg_q.hs_n;
      out_d.vs_n = stg_q.vs_n;
      out_d.fs   = stg_q.fs;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= 3'd0;
      h_cnt_q <= 10'd0;
      v_cnt_q <= 10'd0;
      stg_q   <= STAGE_RST;
      out_q   <= OUT_RST;
    end else begin
      div_q   <= div_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      stg_q   <= stg_d;
      out_q   <= out_d;
    end
  end

  assign rd.rd_x  = h_cnt_q[9:1];
  assign rd.rd_y  = v_cnt_q[8:1];
  assign rd.rd_en = pix_en & visible;

  assign VGA_R       = out_q.r;
  assign VGA_G       = out_q.g;
  assign VGA_B       = out_q.b;
  assign VGA_HS      = out_q.hs_n;
  assign VGA_VS      = out_q.vs_n;
  assign frame_start = out_q.fs;
  assign in_vblank   = out_q.vblank;

endmodule

// File: tb/tb_vga_bitmap_scanner.sv
// Bench for vga_bitmap_scanner: a shrunk-timing instance is scoreboarded pixel by pixel,
// a default-timing instance has its first line's sync placement and width measured.
module tb_vga_bitmap_scanner;

  localparam int CLK_DIV = 4;
  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_VIS = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;    // 24
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;    // 12
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;  // 1152
  localparam logic [16:0] RESET_OUTS = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct {
    int          h;
    int          v;
    logic [14:0] px;
    logic        vb_chk;
    logic        vb;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   rst_epoch = 0;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;
  int   rd_en_vblank_hits = 0;

  always #5 clk = ~clk;

  vga_bitmap_scanner_if mif ();
  vga_bitmap_scanner_if fif ();

  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_start, in_vblank;
  logic [3:0] full_r, full_g, full_b;
  logic       full_hs, full_vs, full_fs, full_vb;

  vga_bitmap_scanner #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rd(mif.master),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .frame_start(frame_start), .in_vblank(in_vblank)
  );

  vga_bitmap_scanner dut_full (
    .clk(clk), .reset_n(reset_n), .rd(fif.master),
    .VGA_R(full_r), .VGA_G(full_g), .VGA_B(full_b), .VGA_HS(full_hs), .VGA_VS(full_vs),
    .frame_start(full_fs), .in_vblank(full_vb)
  );

  // Bitmap memories: data valid one clock after rd_en, random noise otherwise.
  always @(posedge clk) begin
    if (mif.rd_en) begin
      case (mode)
        0:       mif.rd_data <= 3'b110;
        1:       mif.rd_data <= mif.rd_x[2:0];
        default: mif.rd_data <= mif.rd_y[2:0];
      endcase
    end else begin
      mif.rd_data <= 3'($urandom);
    end
    fif.rd_data <= fif.rd_en ? 3'b101 : 3'($urandom);
  end

  always @(negedge clk) if (mif.rd_en && in_vblank) rd_en_vblank_hits++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  function automatic logic [16:0] outs();
    return {vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start, in_vblank, mif.rd_en};
  endfunction

  function automatic logic [14:0] exp_px(input int h, input int v, input int m);
    logic [2:0] d;
    logic       vis;
    vis = (h < H_VIS) && (v < V_VIS);
    case (m)
      0:       d = 3'b110;
      1:       d = 3'((h / 2) % 8);
      default: d = 3'((v / 2) % 8);
    endcase
    return {vis ? {4{d[2]}} : 4'h0, vis ? {4{d[1]}} : 4'h0, vis ? {4{d[0]}} : 4'h0,
            !((h >= H_VIS + H_FP) && (h <= H_VIS + H_FP + H_SYNC - 1)),
            !((v >= V_VIS + V_FP) && (v <= V_VIS + V_FP + V_SYNC - 1)),
            (h == 0) && (v == 0)};
  endfunction

  // Monitor: first pixel lands CLK_DIV+1 clocks after release, then one every CLK_DIV.
  initial begin : monitor
    int   ep;
    exp_t e;
    forever begin
      @(posedge reset_n);
      ep = rst_epoch;
      repeat (CLK_DIV + 1) @(posedge clk);
      #1;
      while (ep == rst_epoch && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("px h=%0d v=%0d", e.h, e.v),
              {vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start}, e.px);
        if (e.vb_chk) check($sformatf("in_vblank v=%0d", e.v), in_vblank, e.vb);
        repeat (CLK_DIV) @(posedge clk);
        #1;
      end
    end
  end

  task automatic push_pixels(input int n, input int m);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.h      = i % H_TOTAL;
      e.v      = (i / H_TOTAL) % V_TOTAL;
      e.px     = exp_px(e.h, e.v, m);
      e.vb_chk = (e.h == 0);
      e.vb     = (e.v >= V_VIS);
      sb.push_back(e);
    end
  endtask

  task automatic run_segment(input int m, input int npix);
    int n;
    @(negedge clk);
    reset_n = 1'b0;
    rst_epoch++;
    sb.delete();
    mode = m;
    push_pixels(npix, m);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < npix * CLK_DIV + 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check($sformatf("drain mode=%0d", m), sb.size(), 0);
  endtask

  task automatic wait_fs(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_start && n < budget);
  endtask

  function automatic logic sel_sig(input int which);
    return (which == 0) ? vga_hs : vga_vs;
  endfunction

  task automatic measure_low(input int which, input int budget, output int w);
    int n;
    n = 0;
    while (!sel_sig(which) && n < budget) begin @(posedge clk); #1; n++; end
    while (sel_sig(which) && n < budget) begin @(posedge clk); #1; n++; end
    w = 0;
    while (!sel_sig(which) && n < budget) begin @(posedge clk); #1; n++; w++; end
  endtask

  initial begin : stimulus
    int n;
    // Reset held with noisy rd_data: outputs pinned at reset values.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_hold", outs(), RESET_OUTS);
    end
    check("reset_rd_xy", {mif.rd_x, mif.rd_y}, 17'h0);

    // Constant colour over a full frame plus one line, then sync/frame timing.
    run_segment(0, H_TOTAL * V_TOTAL + H_TOTAL);
    wait_fs(FRAME_CLKS + 100, n);
    wait_fs(FRAME_CLKS + 100, n);
    check("frame_period", n, FRAME_CLKS);
    measure_low(0, 3 * FRAME_CLKS, n);
    check("hs_low_width", n, H_SYNC * CLK_DIV);
    measure_low(1, 3 * FRAME_CLKS, n);
    check("vs_low_width", n, V_SYNC * H_TOTAL * CLK_DIV);

    // Column-coded and row-coded bitmaps exercise rd_x and rd_y doubling.
    run_segment(1, H_TOTAL * V_TOTAL + H_TOTAL);
    run_segment(2, H_TOTAL * V_TOTAL + H_TOTAL);

    // Mid-frame reset pulse on a visible line.
    run_segment(1, 5 * H_TOTAL + 11);
    @(negedge clk);
    check("pre_reset_nonzero", (vga_r != 4'h0), 1'b1);
    reset_n = 1'b0;
    rst_epoch++;
    #1;
    check("reset_async", outs(), RESET_OUTS);
    check("reset_async_rd_xy", {mif.rd_x, mif.rd_y}, 17'h0);
    repeat (3) @(negedge clk);
    check("reset_pulse_hold", outs(), RESET_OUTS);
    reset_n = 1'b1;
    wait_fs(20, n);
    check("fs_after_reset", n, CLK_DIV + 1);
    wait_fs(FRAME_CLKS + 100, n);
    check("frame_period_after_reset", n, FRAME_CLKS);

    // Default 640x480 timing: first pixel colour, HS placement and width on line 0.
    @(negedge clk);
    reset_n = 1'b0;
    rst_epoch++;
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("full_px00", {full_r, full_g, full_b, full_fs}, {4'hF, 4'h0, 4'hF, 1'b1});
    n = 5;
    while (full_hs && n < 4000) begin @(posedge clk); #1; n++; end
    check("full_hs_fall", n, 656 * 4 + 5);
    n = 0;
    while (!full_hs && n < 1000) begin @(posedge clk); #1; n++; end
    check("full_hs_low_width", n, 384);

    check("rd_en_in_vblank", rd_en_vblank_hits, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
